// File: rtl/decode_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | decode_pkg - opcode constants, control encodings and decode helpers    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package decode_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        result_src_e result_src;
        alu_ctrl_e   alu_control;
    } ctrl_t;

    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c.reg_write   = 1'b0;
        c.mem_write   = 1'b0;
        c.branch      = 1'b0;
        c.jump        = 1'b0;
        c.alu_src     = 1'b0;
        c.result_src  = RES_ALU;
        c.alu_control = ALU_ADD;
        return c;
    endfunction

    // sub_en is only set for R-type with Instr[30]; unlisted funct3 values fall back to add.
    function automatic alu_ctrl_e alu_funct(input logic [2:0] f3, input logic sub_en);
        alu_ctrl_e a;
        case (f3)
            F3_ADD:  a = sub_en ? ALU_SUB : ALU_ADD;
            F3_SLT:  a = ALU_SLT;
            F3_OR:   a = ALU_OR;
            F3_AND:  a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_bypass - 2R/1W register file, x0 hardwired, write-to-read bypass|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module regfile_bypass
    import decode_pkg::*;
#(
    parameter int  XLEN = XLEN_DEFAULT,
    parameter int  NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // A same-cycle write to the address being read is forwarded so decode sees it now.
    always_comb begin
        rdata1 = mem_q[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = mem_q[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage_hc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | decode_stage_hc - RV32 subset decode, register read and ID/EX register |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module decode_stage_hc
    import decode_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallE,
    input  logic            FlushE,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            ValidE,
    output logic            IllegalE
);

    localparam int AW = $clog2(NREG);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    ctrl_t           ctrl_dec;
    imm_src_e        imm_src;
    logic            illegal_dec;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rd1_dec;
    logic [XLEN-1:0] rd2_dec;

    ctrl_t           ctrl_q,    ctrl_d;
    logic [XLEN-1:0] rd1_q,     rd1_d;
    logic [XLEN-1:0] rd2_q,     rd2_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] pc4_q,     pc4_d;
    logic [4:0]      rs1_q,     rs1_d;
    logic [4:0]      rs2_q,     rs2_d;
    logic [4:0]      rd_q,      rd_d;
    logic            valid_q,   valid_d;
    logic            illegal_q, illegal_d;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    always_comb begin
        ctrl_dec    = ctrl_bubble();
        imm_src     = IMM_I;
        illegal_dec = 1'b0;
        case (opcode)
            OP_LOAD: begin
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.alu_src    = 1'b1;
                ctrl_dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl_dec.mem_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                imm_src            = IMM_S;
            end
            OP_RTYPE: begin
                ctrl_dec.reg_write   = 1'b1;
                ctrl_dec.alu_control = alu_funct(funct3, InstrD[30]);
            end
            OP_IALU: begin
                ctrl_dec.reg_write   = 1'b1;
                ctrl_dec.alu_src     = 1'b1;
                ctrl_dec.alu_control = alu_funct(funct3, 1'b0);
            end
            OP_BRANCH: begin
                ctrl_dec.branch      = 1'b1;
                ctrl_dec.alu_control = ALU_SUB;
                imm_src              = IMM_B;
            end
            OP_JAL: begin
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.jump       = 1'b1;
                ctrl_dec.result_src = RES_PC4;
                imm_src             = IMM_J;
            end
            default: begin
                illegal_dec = 1'b1;
            end
        endcase
    end

    always_comb begin
        case (imm_src)
            IMM_S:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                                InstrD[11:8], 1'b0};
            IMM_J:   imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                                InstrD[30:21], 1'b0};
            default: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
        endcase
    end

    regfile_bypass #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (RegWriteW),
        .waddr  (RdW[AW-1:0]),
        .wdata  (ResultW),
        .raddr1 (Rs1D[AW-1:0]),
        .raddr2 (Rs2D[AW-1:0]),
        .rdata1 (rd1_dec),
        .rdata2 (rd2_dec)
    );

    // Flush beats stall; an invalid slot keeps its data but cannot write, branch or trap.
    always_comb begin
        ctrl_d    = ctrl_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        pc4_d     = pc4_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        if (FlushE) begin
            ctrl_d    = ctrl_bubble();
            rd1_d     = '0;
            rd2_d     = '0;
            imm_d     = '0;
            pc_d      = '0;
            pc4_d     = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (!StallE) begin
            ctrl_d           = ctrl_dec;
            ctrl_d.reg_write = ctrl_dec.reg_write & ValidD;
            ctrl_d.mem_write = ctrl_dec.mem_write & ValidD;
            ctrl_d.branch    = ctrl_dec.branch & ValidD;
            ctrl_d.jump      = ctrl_dec.jump & ValidD;
            rd1_d            = rd1_dec;
            rd2_d            = rd2_dec;
            imm_d            = imm_ext;
            pc_d             = PCD;
            pc4_d            = PCPlus4D;
            rs1_d            = Rs1D;
            rs2_d            = Rs2D;
            rd_d             = InstrD[11:7];
            valid_d          = ValidD;
            illegal_d        = illegal_dec & ValidD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= ctrl_bubble();
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            pc4_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            pc4_q     <= pc4_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign BranchE     = ctrl_q.branch;
    assign JumpE       = ctrl_q.jump;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign ResultSrcE  = ctrl_q.result_src;
    assign ALUControlE = ctrl_q.alu_control;
    assign RD1_E       = rd1_q;
    assign RD2_E       = rd2_q;
    assign ImmExtE     = imm_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc4_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign ValidE      = valid_q;
    assign IllegalE    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_decode_stage_hc - directed and random checks against a decode model |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_decode_stage_hc;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD, PCPlus4D, ResultW;
    logic            ValidD, RegWriteW, StallE, FlushE;
    logic [4:0]      RdW;
    logic [4:0]      Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic            RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ValidE, IllegalE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: architectural registers and the expected E-stage contents
    logic [31:0] regs [32];
    logic        e_rw, e_mw, e_br, e_jp, e_as, e_v, e_ill;
    logic [1:0]  e_rsrc;
    logic [2:0]  e_alu;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
    logic [4:0]  e_rs1, e_rs2, e_rd;

    always #5 clk = ~clk;

    decode_stage_hc #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallE(StallE), .FlushE(FlushE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .IllegalE(IllegalE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_e();
        {e_rw, e_mw, e_br, e_jp, e_as, e_v, e_ill} = '0;
        e_rsrc = '0; e_alu = '0;
        e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_pc = '0; e_pc4 = '0;
        e_rs1 = '0; e_rs2 = '0; e_rd = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        clear_e();
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWriteW && RdW == a) return ResultW;
        return regs[a];
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Applies the effect of one rising edge with the current inputs.
    task automatic model_cycle();
        logic rw, mw, br, jp, as, ill;
        logic [1:0] rsrc;
        logic [2:0] alu;
        logic [31:0] imm;
        if (FlushE) begin
            clear_e();
        end else if (!StallE) begin
            {rw, mw, br, jp, as, ill} = '0;
            rsrc = 2'd0; alu = 3'd0;
            imm = 32'($signed(InstrD[31:20]));
            case (InstrD[6:0])
                7'b0000011: begin rw = 1; as = 1; rsrc = 2'd1; end
                7'b0100011: begin mw = 1; as = 1;
                                  imm = 32'($signed({InstrD[31:25], InstrD[11:7]})); end
                7'b0110011: begin rw = 1; alu = alu_of(InstrD[14:12], InstrD[30]); end
                7'b0010011: begin rw = 1; as = 1; alu = alu_of(InstrD[14:12], 1'b0); end
                7'b1100011: begin br = 1; alu = 3'b001;
                                  imm = 32'($signed({InstrD[31], InstrD[7], InstrD[30:25],
                                                     InstrD[11:8], 1'b0})); end
                7'b1101111: begin rw = 1; jp = 1; rsrc = 2'd2;
                                  imm = 32'($signed({InstrD[31], InstrD[19:12], InstrD[20],
                                                     InstrD[30:21], 1'b0})); end
                default:    ill = 1;
            endcase
            e_rw = rw & ValidD; e_mw = mw & ValidD; e_br = br & ValidD; e_jp = jp & ValidD;
            e_v = ValidD; e_ill = ill & ValidD;
            e_as = as; e_rsrc = rsrc; e_alu = alu; e_imm = imm;
            e_rd1 = rf_read(InstrD[19:15]); e_rd2 = rf_read(InstrD[24:20]);
            e_pc = PCD; e_pc4 = PCPlus4D;
            e_rs1 = InstrD[19:15]; e_rs2 = InstrD[24:20]; e_rd = InstrD[11:7];
        end
        if (RegWriteW && RdW != 5'd0) regs[RdW] = ResultW;
    endtask

    task automatic check_e();
        chk("RegWriteE",   32'(RegWriteE),   32'(e_rw));
        chk("MemWriteE",   32'(MemWriteE),   32'(e_mw));
        chk("BranchE",     32'(BranchE),     32'(e_br));
        chk("JumpE",       32'(JumpE),       32'(e_jp));
        chk("ALUSrcE",     32'(ALUSrcE),     32'(e_as));
        chk("ResultSrcE",  32'(ResultSrcE),  32'(e_rsrc));
        chk("ALUControlE", 32'(ALUControlE), 32'(e_alu));
        chk("RD1_E",       RD1_E,            e_rd1);
        chk("RD2_E",       RD2_E,            e_rd2);
        chk("ImmExtE",     ImmExtE,          e_imm);
        chk("PCE",         PCE,              e_pc);
        chk("PCPlus4E",    PCPlus4E,         e_pc4);
        chk("Rs1E",        32'(Rs1E),        32'(e_rs1));
        chk("Rs2E",        32'(Rs2E),        32'(e_rs2));
        chk("RdE",         32'(RdE),         32'(e_rd));
        chk("ValidE",      32'(ValidE),      32'(e_v));
        chk("IllegalE",    32'(IllegalE),    32'(e_ill));
    endtask

    // Inputs are already driven; check decode addresses, take one edge, check E state.
    task automatic step();
        #1;
        chk("Rs1D", 32'(Rs1D), 32'(InstrD[19:15]));
        chk("Rs2D", 32'(Rs2D), 32'(InstrD[24:20]));
        model_cycle();
        @(posedge clk);
        #1;
        check_e();
    endtask

    task automatic drive(input logic [31:0] ins, input logic rw, input logic [4:0] rd,
                         input logic [31:0] res);
        InstrD = ins; RegWriteW = rw; RdW = rd; ResultW = res;
        PCD = PCD + 32'd4; PCPlus4D = PCD + 32'd4;
    endtask

    initial begin
        rst = 1'b1;
        InstrD = '0; PCD = 32'h100; PCPlus4D = 32'h104; ValidD = 1'b1;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0; StallE = 1'b0; FlushE = 1'b0;
        clear_model();
        #2 rst = 1'b0;
        #1 check_e();
        @(negedge clk) rst = 1'b1;

        drive(32'h0000_0033, 1'b1, 5'd1, 32'd5);      step();
        drive(32'h0000_0033, 1'b1, 5'd2, 32'd7);      step();
        drive(32'h0000_0033, 1'b1, 5'd5, 32'h1234);   step();

        drive(32'h0020_81B3, 1'b0, 5'd0, 32'd0);      step();
        chk("add_rd1", RD1_E, 32'd5);
        chk("add_rd2", RD2_E, 32'd7);
        chk("add_alu", 32'(ALUControlE), 32'd0);
        chk("add_regwrite", 32'(RegWriteE), 32'd1);
        chk("add_rd", 32'(RdE), 32'd3);

        drive(32'h0020_81B3, 1'b1, 5'd1, 32'h55);     step();
        chk("bypass_rd1", RD1_E, 32'h55);
        drive(32'h0020_01B3, 1'b1, 5'd0, 32'h99);     step();
        chk("x0_bypass", RD1_E, 32'd0);
        drive(32'h0020_01B3, 1'b0, 5'd0, 32'd0);      step();
        chk("x0_after_write", RD1_E, 32'd0);

        drive(32'hFE20_AE23, 1'b0, 5'd0, 32'd0);      step();
        chk("sw_imm", ImmExtE, 32'hFFFF_FFFC);
        chk("sw_memwrite", 32'(MemWriteE), 32'd1);
        chk("sw_regwrite", 32'(RegWriteE), 32'd0);
        StallE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(32'h0080_00EF, 1'b1, 5'd4, 32'hABCD);   step();
            chk("stall_imm", ImmExtE, 32'hFFFF_FFFC);
            chk("stall_memwrite", 32'(MemWriteE), 32'd1);
        end
        FlushE = 1'b1;
        drive(32'h0080_00EF, 1'b0, 5'd0, 32'd0);      step();
        chk("flush_regwrite", 32'(RegWriteE), 32'd0);
        chk("flush_valid", 32'(ValidE), 32'd0);
        chk("flush_imm", ImmExtE, 32'd0);
        StallE = 1'b0; FlushE = 1'b0;

        drive(32'h0080_00EF, 1'b0, 5'd0, 32'd0);      step();
        chk("jal_resultsrc", 32'(ResultSrcE), 32'd2);
        chk("jal_jump", 32'(JumpE), 32'd1);
        chk("jal_imm", ImmExtE, 32'd8);
        drive(32'h0002_01B3, 1'b0, 5'd0, 32'd0);      step();
        chk("stall_rf_write", RD1_E, 32'hABCD);

        drive(32'h0000_007F, 1'b0, 5'd0, 32'd0);      step();
        chk("ill_flag", 32'(IllegalE), 32'd1);
        chk("ill_regwrite", 32'(RegWriteE), 32'd0);
        chk("ill_memwrite", 32'(MemWriteE), 32'd0);
        ValidD = 1'b0;
        drive(32'h0000_007F, 1'b0, 5'd0, 32'd0);      step();
        chk("ill_invalid", 32'(IllegalE), 32'd0);
        ValidD = 1'b1;

        drive(32'h0020_81B3, 1'b0, 5'd0, 32'd0);      step();
        StallE = 1'b1;
        #3 rst = 1'b0;
        clear_model();
        #1 check_e();
        chk("rst_async_valid", 32'(ValidE), 32'd0);
        @(posedge clk);
        #1 check_e();
        @(negedge clk);
        rst = 1'b1; StallE = 1'b0;
        drive(32'h0002_8333, 1'b0, 5'd0, 32'd0);      step();
        chk("x5_after_reset", RD1_E, 32'd0);
        chk("fresh_after_reset", 32'(ValidE), 32'd1);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            logic [4:0]  wr;
            ins = $urandom;
            case ($urandom_range(0, 7))
                0: ins[6:0] = 7'b0000011;
                1: ins[6:0] = 7'b0100011;
                2: ins[6:0] = 7'b0110011;
                3: ins[6:0] = 7'b0010011;
                4: ins[6:0] = 7'b1100011;
                5: ins[6:0] = 7'b1101111;
                6: ins[6:0] = 7'b1111111;
                default: ins[6:0] = 7'b0110111;
            endcase
            wr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ins[19:15] = wr;
            if ($urandom_range(0, 3) == 0) ins[24:20] = wr;
            ValidD = ($urandom_range(0, 9) != 0);
            StallE = ($urandom_range(0, 9) < 2);
            FlushE = ($urandom_range(0, 9) == 0);
            drive(ins, 1'($urandom_range(0, 1)), wr, $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage_hc.md
DECODE_STAGE_HC -- requirements
Module: decode_stage_hc

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count; register address width is clog2(NREG).
REQ-003 SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have inputs InstrD (32), PCD (XLEN), PCPlus4D (XLEN) and ValidD (1): the instruction in decode.
REQ-006 SHALL have inputs RegWriteW (1), RdW (5) and ResultW (XLEN): the writeback port.
REQ-007 SHALL have inputs StallE (1), which holds ID/EX, and FlushE (1), which inserts a bubble into ID/EX.
REQ-008 SHALL have outputs Rs1D (5) and Rs2D (5): combinational source addresses for the hazard unit.
REQ-009 SHALL have registered control outputs RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE (1 each), ResultSrcE (2) and ALUControlE (3).
REQ-010 SHALL have registered data outputs RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E (XLEN each), Rs1E, Rs2E, RdE (5 each), ValidE (1) and IllegalE (1).

Function
REQ-011 SHALL decode these opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU, 1100011 beq, 1101111 jal. Any other opcode is illegal: all write/branch/jump controls are 0 and IllegalE is 1.
REQ-012 SHALL encode ImmSrc as 00 I, 01 S, 10 B, 11 J; ImmExt SHALL be sign-extended to XLEN from Instr[31].
REQ-013 SHALL encode ResultSrc as 00 ALU, 01 memory, 10 PC+4 (jal).
REQ-014 SHALL encode ALUControl as 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-015 SHALL select sub for R-type when funct3=000 and Instr[30]=1; lw/sw SHALL use add; beq SHALL use sub.
REQ-016 SHALL hold a register file of NREG x XLEN entries with x0 reading as 0; writes to x0 SHALL be ignored.
REQ-017 SHALL write the register file on the rising clk edge when RegWriteW=1 and RdW!=0.
REQ-018 SHALL bypass on a same-cycle collision: a read of address A while RegWriteW=1 and RdW=A!=0 returns ResultW in that cycle.
REQ-019 SHALL give ID/EX a latency of 1 cycle: the decode values of cycle n appear on the E outputs in cycle n+1.
REQ-020 SHALL give FlushE priority over StallE: with FlushE=1, RegWriteE, MemWriteE, BranchE, JumpE, ValidE and IllegalE become 0 and the remaining E fields become 0.
REQ-021 SHALL hold every E output at the next edge when StallE=1 and FlushE=0; the register file write still occurs.
REQ-022 SHALL force the same control outputs to 0 as a flush when ValidD=0, with the other fields captured normally.
REQ-023 SHALL capture IllegalE only when ValidD=1; an illegal instruction SHALL never assert RegWriteE or MemWriteE.
REQ-024 SHALL take Rs1D and Rs2D from InstrD[19:15] and InstrD[24:20], and SHALL register them into Rs1E and Rs2E.

Reset
REQ-025 SHALL clear every ID/EX output to 0 immediately while rst=0, independent of clk.
REQ-026 SHALL clear all register-file entries to 0 while rst=0.
REQ-027 SHALL, if reset is asserted mid-stall, win over StallE; the first edge after release captures fresh decode.

Structure
REQ-028 SHALL place opcode constants, the ImmSrc/ResultSrc/ALUControl encodings and the XLEN default in a shared package, decode_pkg.
REQ-029 SHALL implement the register file, including bypass, as one sub-module, regfile_bypass; the decoders stay inline.
REQ-030 SHALL fit in 120-400 lines of RTL.

Verification
REQ-031 Reset check: rst low mid-cycle -> all E outputs 0 immediately; x5 reads 0 after release.
REQ-032 Decode check: add x3,x1,x2 (0x002081B3) with x1=5, x2=7 -> next cycle RD1_E=5, RD2_E=7, ALUControlE=000, RegWriteE=1, RdE=3.
REQ-033 Bypass check: RegWriteW=1, RdW=1, ResultW=0x55 in the same cycle as a decode reading x1 -> RD1_E=0x55; RdW=0 with 0x99 -> x0 reads 0.
REQ-034 Stall/flush check: StallE=1 for 2 cycles -> E outputs frozen; StallE=1 and FlushE=1 together -> bubble (RegWriteE=0, ValidE=0).
REQ-035 Immediate check: sw x2,-4(x1) (0xFE20AE23) -> ImmExtE=0xFFFFFFFC, MemWriteE=1, RegWriteE=0; jal x1,+8 -> ResultSrcE=10, JumpE=1, ImmExtE=8.
REQ-036 Illegal check: opcode 1111111 with ValidD=1 -> IllegalE=1, RegWriteE=0, MemWriteE=0; with ValidD=0 -> IllegalE=0.
